// File: rtl/serial_cmp_ctrl_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding
// and the index-width helper.
package serial_cmp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to index WIDTH positions, never less than one.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_cmp_ctrl_cell.sv
// Combinational one-bit magnitude compare slice.
module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic eq,
  output logic gt,
  output logic lt
);

  assign eq = ~(a_bit ^ b_bit);
  assign gt = a_bit & ~b_bit;
  assign lt = ~a_bit & b_bit;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial unsigned magnitude comparator: walks captured operands MSB-first
// through one compare cell and reports eq/gt/lt with a one-cycle done pulse.
module serial_cmp_ctrl
  import serial_cmp_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeb,
  output logic             agb,
  output logic             alb,
  output logic [1:0]       o_dbg_state
);

  // Handshake: start is taken only in a cycle where busy=0; a/b are sampled in
  // that same cycle. done is high for exactly one cycle and the flags are
  // valid from that cycle until the next done.

  localparam int IDX_W = clog2_min1(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_aeb;
  logic             r_agb;
  logic             r_alb;
  logic             r_diff;
  logic             r_dir;

  logic w_a_bit;
  logic w_b_bit;
  logic w_eq;
  logic w_gt;
  logic w_lt;
  logic w_accept;
  logic w_load;
  logic w_dec;
  logic w_res_eq;
  logic w_res_gt;
  logic w_res_lt;
  logic w_diff_any;
  logic w_dir;

  always_comb begin
    w_a_bit = 1'b0;
    w_b_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(r_idx) == i) begin
        w_a_bit = r_a[i];
        w_b_bit = r_b[i];
      end
    end
  end

  cmp_bit_cell u_cell (
    .a_bit (w_a_bit),
    .b_bit (w_b_bit),
    .eq    (w_eq),
    .gt    (w_gt),
    .lt    (w_lt)
  );

  // Full-scan mode: the first difference seen (possibly at bit 0) decides.
  assign w_diff_any = r_diff | ~w_eq;
  assign w_dir      = r_diff ? r_dir : w_gt;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_res_eq = 1'b0;
    w_res_gt = 1'b0;
    w_res_lt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (EARLY_EXIT && !w_eq) begin
          w_load   = 1'b1;
          w_res_gt = w_gt;
          w_res_lt = w_lt;
          w_next   = ST_DONE;
        end else if (r_idx == '0) begin
          w_load   = 1'b1;
          w_res_eq = ~w_diff_any;
          w_res_gt = w_diff_any & w_dir;
          w_res_lt = w_diff_any & ~w_dir;
          w_next   = ST_DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= IDX_TOP;
      r_aeb   <= 1'b0;
      r_agb   <= 1'b0;
      r_alb   <= 1'b0;
      r_diff  <= 1'b0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_idx  <= IDX_TOP;
        r_diff <= 1'b0;
        r_dir  <= 1'b0;
      end
      if (w_dec) begin
        r_idx <= r_idx - IDX_W'(1);
        if (!EARLY_EXIT && !r_diff && !w_eq) begin
          r_diff <= 1'b1;
          r_dir  <= w_gt;
        end
      end
      if (w_load) begin
        r_aeb <= w_res_eq;
        r_agb <= w_res_gt;
        r_alb <= w_res_lt;
      end
    end
  end

  assign busy        = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done        = (r_state == ST_DONE);
  assign aeb         = r_aeb;
  assign agb         = r_agb;
  assign alb         = r_alb;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Bench for serial_cmp_ctrl: three configurations (8-bit early exit, 8-bit full
// scan, 1-bit) compared against an arithmetic model of result and latency.
module tb_serial_cmp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v[3];
  logic [7:0] a_v[3];
  logic [7:0] b_v[3];
  logic       busy_v[3];
  logic       done_v[3];
  logic       aeb_v[3];
  logic       agb_v[3];
  logic       alb_v[3];
  logic [1:0] st_v[3];
  logic [2:0] prev_f[3];

  int         unit_w[3];
  bit         unit_ee[3];
  int         total = 0;
  int         bad = 0;
  logic [2:0] exp_q[$];
  int         lat_q[$];

  always #5 clk = ~clk;

  serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut_ee (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .aeb(aeb_v[0]), .agb(agb_v[0]),
    .alb(alb_v[0]), .o_dbg_state(st_v[0])
  );

  serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut_full (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .aeb(aeb_v[1]), .agb(agb_v[1]),
    .alb(alb_v[1]), .o_dbg_state(st_v[1])
  );

  serial_cmp_ctrl #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_dut_w1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][0:0]), .b(b_v[2][0:0]),
    .busy(busy_v[2]), .done(done_v[2]), .aeb(aeb_v[2]), .agb(agb_v[2]),
    .alb(alb_v[2]), .o_dbg_state(st_v[2])
  );

  // Reference model: plain arithmetic on the masked operands.
  function automatic logic [7:0] width_mask(input int w);
    return 8'((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [2:0] model_flags(input logic [7:0] av, input logic [7:0] bv,
                                             input int w);
    logic [7:0] ma;
    logic [7:0] mb;
    ma = av & width_mask(w);
    mb = bv & width_mask(w);
    return {ma == mb, ma > mb, ma < mb};
  endfunction

  function automatic int model_lat(input logic [7:0] av, input logic [7:0] bv,
                                   input int w, input bit ee);
    logic [7:0] x;
    int k;
    x = (av ^ bv) & width_mask(w);
    k = -1;
    for (int i = 0; i < w; i++) if (x[i]) k = i;
    if (ee && k >= 0) return 2 + (w - 1 - k);
    return w + 1;
  endfunction

  // Drives one compare and measures it; lat = -1 if done never arrives.
  task automatic run_cmp(input int u, input logic [7:0] av, input logic [7:0] bv,
                         input bit scramble, output int lat, output logic [2:0] flags,
                         output logic [2:0] pre_flags, output int busy_cnt);
    @(posedge clk); #1;
    a_v[u] = av; b_v[u] = bv; start_v[u] = 1'b1;
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    lat = -1; busy_cnt = 0; flags = '0; pre_flags = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) pre_flags = {aeb_v[u], agb_v[u], alb_v[u]};
      if (busy_v[u]) busy_cnt++;
      if (done_v[u]) begin
        lat = n;
        flags = {aeb_v[u], agb_v[u], alb_v[u]};
        break;
      end
      if (scramble) begin
        a_v[u] = 8'($urandom);
        b_v[u] = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      got = {busy_v[u], done_v[u], aeb_v[u], agb_v[u], alb_v[u], st_v[u] != 2'd0};
      total++;
      if (got !== 6'd0) begin
        bad++;
        $display("FAIL reset u%0d got=%b exp=000000", u, got);
      end
      prev_f[u] = 3'b000;
    end
  endtask

  task automatic test_directed();
    int         tu[5];
    logic [7:0] ta[5];
    logic [7:0] tb[5];
    int         lat, bcnt, el;
    logic [2:0] fl, pre, ef;
    tu = '{0, 0, 0, 1, 1};
    ta = '{8'h80, 8'h3C, 8'h3C, 8'hF0, 8'h3C};
    tb = '{8'h7F, 8'h3C, 8'h3D, 8'h0F, 8'h3C};
    for (int i = 0; i < 5; i++) begin
      run_cmp(tu[i], ta[i], tb[i], 1'b0, lat, fl, pre, bcnt);
      el = model_lat(ta[i], tb[i], unit_w[tu[i]], unit_ee[tu[i]]);
      ef = model_flags(ta[i], tb[i], unit_w[tu[i]]);
      total++;
      if (lat !== el) begin
        bad++;
        $display("FAIL dir_lat #%0d got=%0d exp=%0d", i, lat, el);
      end
      total++;
      if (fl !== ef) begin
        bad++;
        $display("FAIL dir_flags #%0d got=%b exp=%b", i, fl, ef);
      end
      total++;
      if (bcnt !== el) begin
        bad++;
        $display("FAIL dir_busy #%0d got=%0d exp=%0d", i, bcnt, el);
      end
      total++;
      if (pre !== prev_f[tu[i]]) begin
        bad++;
        $display("FAIL dir_hold_on_start #%0d got=%b exp=%b", i, pre, prev_f[tu[i]]);
      end
      prev_f[tu[i]] = ef;
    end
  endtask

  task automatic test_width1();
    logic [7:0] ta[3];
    logic [7:0] tb[3];
    logic [2:0] ef[3];
    int         lat, bcnt;
    logic [2:0] fl, pre, got;
    ta = '{8'h01, 8'h00, 8'h00};
    tb = '{8'h00, 8'h00, 8'h01};
    ef = '{3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 3; i++) begin
      run_cmp(2, ta[i], tb[i], 1'b0, lat, fl, pre, bcnt);
      total++;
      if (lat !== 2) begin
        bad++;
        $display("FAIL w1_lat #%0d got=%0d exp=2", i, lat);
      end
      total++;
      if (fl !== ef[i]) begin
        bad++;
        $display("FAIL w1_flags #%0d got=%b exp=%b", i, fl, ef[i]);
      end
      prev_f[2] = ef[i];
    end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      got = {aeb_v[2], agb_v[2], alb_v[2]};
      total++;
      if (got !== prev_f[2] || done_v[2] !== 1'b0) begin
        bad++;
        $display("FAIL w1_idle_hold cyc%0d got=%b done=%b exp=%b done=0", n, got, done_v[2],
                 prev_f[2]);
      end
    end
  endtask

  task automatic test_random();
    int         u, lat, bcnt, el;
    logic [7:0] av, bv;
    logic [2:0] fl, pre, ef;
    bit         scr;
    for (int i = 0; i < 30; i++) begin
      u  = i % 3;
      av = 8'($urandom);
      bv = 8'($urandom);
      case ($urandom_range(0, 3))
        0: bv = av;
        1: bv = av ^ (8'd1 << $urandom_range(0, 7));
        default: ;
      endcase
      scr = 1'($urandom_range(0, 1));
      run_cmp(u, av, bv, scr, lat, fl, pre, bcnt);
      el = model_lat(av, bv, unit_w[u], unit_ee[u]);
      ef = model_flags(av, bv, unit_w[u]);
      total++;
      if (lat !== el) begin
        bad++;
        $display("FAIL rnd_lat u%0d a=%h b=%h got=%0d exp=%0d", u, av, bv, lat, el);
      end
      total++;
      if (fl !== ef) begin
        bad++;
        $display("FAIL rnd_flags u%0d a=%h b=%h got=%b exp=%b", u, av, bv, fl, ef);
      end
      total++;
      if (pre !== prev_f[u]) begin
        bad++;
        $display("FAIL rnd_hold_on_start u%0d got=%b exp=%b", u, pre, prev_f[u]);
      end
      prev_f[u] = ef;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa[2];
    logic [7:0] pb[2];
    int         exp_cyc, dones, extra;
    logic [2:0] got, e;
    pa = '{8'h80, 8'h55};
    pb = '{8'h01, 8'h55};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(model_flags(pa[i%2], pb[i%2], 8));
      lat_q.push_back(model_lat(pa[i%2], pb[i%2], 8, 1'b1));
    end
    @(posedge clk); #1;
    a_v[0] = pa[0]; b_v[0] = pb[0]; start_v[0] = 1'b1;
    @(posedge clk);
    exp_cyc = lat_q.pop_front();
    dones = 0;
    for (int n = 1; n <= 200 && dones < 6; n++) begin
      @(negedge clk);
      if (done_v[0]) begin
        total++;
        if (n !== exp_cyc) begin
          bad++;
          $display("FAIL b2b_timing #%0d got_cyc=%0d exp_cyc=%0d", dones, n, exp_cyc);
        end
        e = exp_q.pop_front();
        got = {aeb_v[0], agb_v[0], alb_v[0]};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL b2b_flags #%0d got=%b exp=%b", dones, got, e);
        end
        dones++;
        if (dones < 6) begin
          a_v[0] = pa[dones%2];
          b_v[0] = pb[dones%2];
          exp_cyc = n + 1 + lat_q.pop_front();
        end else begin
          start_v[0] = 1'b0;
        end
      end else if (busy_v[0]) begin
        a_v[0] = 8'($urandom);
        b_v[0] = 8'($urandom);
      end
    end
    start_v[0] = 1'b0;
    total++;
    if (dones !== 6) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=6", dones);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL b2b_extra_done got=%0d exp=0", extra);
    end
    prev_f[0] = model_flags(pa[1], pb[1], 8);
    exp_q.delete();
    lat_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [5:0] got;
    int         seen, lat, bcnt;
    logic [2:0] fl, pre, ef;
    @(posedge clk); #1;
    a_v[0] = 8'h3C; b_v[0] = 8'h3C; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    got = {busy_v[0], done_v[0], aeb_v[0], agb_v[0], alb_v[0], st_v[0] != 2'd0};
    total++;
    if (got !== 6'd0) begin
      bad++;
      $display("FAIL midrst_state got=%b exp=000000", got);
    end
    for (int u = 0; u < 3; u++) prev_f[u] = 3'b000;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL midrst_no_done got=%0d exp=0", seen);
    end
    run_cmp(0, 8'h21, 8'h23, 1'b1, lat, fl, pre, bcnt);
    ef = model_flags(8'h21, 8'h23, 8);
    total++;
    if (lat !== model_lat(8'h21, 8'h23, 8, 1'b1) || fl !== ef) begin
      bad++;
      $display("FAIL midrst_after lat=%0d flags=%b exp_lat=%0d exp_flags=%b", lat, fl,
               model_lat(8'h21, 8'h23, 8, 1'b1), ef);
    end
    total++;
    if (pre !== 3'b000) begin
      bad++;
      $display("FAIL midrst_cleared_flags got=%b exp=000", pre);
    end
  endtask

  initial begin
    unit_w  = '{8, 8, 1};
    unit_ee = '{1'b1, 1'b0, 1'b1};
    for (int u = 0; u < 3; u++) begin
      start_v[u] = 1'b0;
      a_v[u] = 8'h00;
      b_v[u] = 8'h00;
    end
    test_reset();
    test_directed();
    test_width1();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
- Sequential magnitude comparator controller. Captures two unsigned WIDTH-bit operands on a start handshake.
- Walks them MSB-first through a single 1-bit compare cell, one bit per clock. Reports exactly one of equal, greater or less, qualified by a one-cycle done pulse.
- Used where area matters more than latency: it replaces a wide parallel comparator with one bit-slice plus sequencing.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..32.
- EARLY_EXIT, 1, 1 = finish at first differing bit; 0 = always scan all WIDTH bits (constant latency).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a compare; accepted only when busy=0
- a  input  WIDTH  operand A, unsigned; sampled only in the accept cycle
- b  input  WIDTH  operand B, unsigned; sampled only in the accept cycle
- busy  output  1  high in RUN and DONE states
- done  output  1  one-cycle pulse; results valid and updated in this cycle
- aeb  output  1  a equal b
- agb  output  1  a greater than b
- alb  output  1  a less than b

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset is synchronous and active-high (rst).
  - Reset values: state=IDLE, busy=0, done=0, aeb=0, agb=0, alb=0, operand registers=0, bit index=WIDTH-1.
- State machine, three states:
  - IDLE: if start=1, capture a/b into internal registers, set index=WIDTH-1, go to RUN. Otherwise stay.
  - RUN: compare captured bit[index] of A and B through the cell.
    - EARLY_EXIT=1 and bits differ: load result (agb=A bit, alb=B bit, aeb=0) and go to DONE.
    - Bits equal and index=0: load aeb=1, agb=0, alb=0 and go to DONE.
    - Otherwise decrement index and stay in RUN.
  - RUN with EARLY_EXIT=0: record the first difference in a sticky flag plus direction bit. Continue scanning; load the result at index=0 and go to DONE.
  - DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency: start accepted at cycle T.
  - EARLY_EXIT=1, first differing bit k: done asserted at T+2+(WIDTH-1-k).
  - Equal operands, or EARLY_EXIT=0: done at T+WIDTH+1.
- Result rules:
  - Result flags change only on the transition into DONE.
  - They hold until the next DONE; they are not cleared on start.
  - After the first completion exactly one of aeb/agb/alb is 1. Before any completion all three are 0.
- start while busy=1 (RUN or DONE) is ignored and never queued. Back-to-back throughput is one compare per WIDTH+2 cycles worst case.
- a/b changes after the accept cycle have no effect on the running compare.
- rst asserted in any state, including mid-RUN: next cycle is IDLE with reset values. The partial compare is discarded and no done is issued.
- WIDTH=1: RUN lasts one cycle; done at T+2.
- Index register width is clog2(WIDTH), minimum 1. Decrement never wraps below 0.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 unreachable; decode to IDLE).
  - a clog2 helper function for the index width.
- One sub-module: cmp_bit_cell. Combinational single-bit compare, inputs a_bit/b_bit, outputs eq/gt/lt. It is instantiated once, fed by the indexed operand bits.
- All sequencing stays in serial_cmp_ctrl.

Test Plan:
1. WIDTH=8, EARLY_EXIT=1; a=8'h80, b=8'h7F, start at T -> done at T+2, agb=1, aeb=0, alb=0, busy high T+1..T+2.
2. a=8'h3C, b=8'h3C -> done at T+9, aeb=1, agb=0, alb=0. Then a=8'h3C, b=8'h3D -> done at T+9 (bit0 differs), alb=1.
3. EARLY_EXIT=0; a=8'hF0, b=8'h0F -> done at T+9 (not T+2), agb=1.
4. start held high continuously with alternating operands -> accepts only in IDLE, one done per compare, no dropped or duplicated pulses. a/b toggled during RUN do not alter the result.
5. Assert rst for one cycle at T+3 of a 9-cycle compare -> next cycle IDLE, all outputs 0, no done. A new start afterwards completes normally.
6. WIDTH=1: a=1, b=0 -> done at T+2 with agb=1. a=0, b=0 -> aeb=1. Flags hold between compares while idle.
